// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
//
// Instruction prefetch stage. It keeps a 16-bit fetch IP and issues one byte
// read at a time to memory at the physical address (CS << 4) + IP. Fetched
// bytes are buffered in a small FIFO that the decoder drains.
//
// A flush throws away the queue and any request in flight. Fetching then
// restarts at flush_ip, for example after a jump or a CS write.
//
// Parameters:
//   DEPTH     queue capacity in bytes (2..15)
//   CNT_W     width of q_count; must be able to hold the value DEPTH
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset (highest priority)
//   cs_in     code segment from the segment register file
//   flush     discard the queue and restart fetching at flush_ip
//   flush_ip  new fetch IP, sampled while flush=1
//   mem_req   read request, held until mem_ack
//   mem_addr  20-bit physical byte address, stable while mem_req=1
//   mem_ack   memory accepts the request; mem_rdata is valid in this cycle
//   mem_rdata read byte
//   q_valid   queue is not empty
//   q_byte    byte at the queue head
//   q_pop     decoder consumes the head byte
//   q_count   number of bytes held
//   fetch_ip  IP of the next byte to be requested
//
// Optional feature (macro PREFETCH_STATS_EN):
//   stat_fetches  saturating count of accepted fetch pushes
//   stat_flushes  saturating count of flush cycles
// -----------------------------------------------------------------------------
module prefetch_queue #(
  parameter int DEPTH = 6,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      cs_in,
  input  logic             flush,
  input  logic [15:0]      flush_ip,
  output logic             mem_req,
  output logic [19:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [7:0]       mem_rdata,
  output logic             q_valid,
  output logic [7:0]       q_byte,
  input  logic             q_pop,
  output logic [CNT_W-1:0] q_count,
  output logic [15:0]      fetch_ip
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]      stat_fetches,
  output logic [15:0]      stat_flushes
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Physical address. The carry out of bit 19 is dropped because the sum is
  // truncated to 20 bits.
  function automatic logic [19:0] phys_addr(input logic [15:0] seg,
                                            input logic [15:0] ip);
    return {seg, 4'h0} + {4'h0, ip};
  endfunction

  // Advance a queue pointer and wrap it at DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  state_t           state_q,    state_d;
  logic             mem_req_q,  mem_req_d;
  logic [19:0]      mem_addr_q, mem_addr_d;
  logic [15:0]      fetch_ip_q, fetch_ip_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [7:0]       buf_q [DEPTH];
  logic [7:0]       buf_d [DEPTH];

  logic push_s;
  logic pop_s;

  // An ack only counts while a request is outstanding. A flush cancels both
  // the push and the pop in the same cycle.
  assign push_s = (state_q == ST_REQ) && mem_ack && !flush;
  assign pop_s  = q_pop && (count_q != CNT_ZERO) && !flush;

  // Next-state logic for the FSM, the queue pointers, storage and fetch IP.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_ip_d = fetch_ip_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    buf_d      = buf_q;

    if (flush) begin
      state_d    = ST_IDLE;
      mem_req_d  = 1'b0;
      fetch_ip_d = flush_ip;
      count_d    = CNT_ZERO;
      rd_ptr_d   = PTR_ZERO;
      wr_ptr_d   = PTR_ZERO;
    end else begin
      if (push_s) begin
        buf_d[wr_ptr_q] = mem_rdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
        fetch_ip_d      = fetch_ip_q + 16'd1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      case (state_q)
        ST_IDLE: begin
          if (count_q < DEPTH_C) begin
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = phys_addr(cs_in, fetch_ip_q);
          end else begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            // Issue the next request back-to-back while the queue still has
            // space after this push.
            if (count_d < DEPTH_C) begin
              state_d    = ST_REQ;
              mem_req_d  = 1'b1;
              mem_addr_d = phys_addr(cs_in, fetch_ip_q + 16'd1);
            end else begin
              state_d   = ST_IDLE;
              mem_req_d = 1'b0;
            end
          end else begin
            state_d   = ST_REQ;
            mem_req_d = 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  // State, queue and address registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 20'h00000;
      fetch_ip_q <= 16'h0000;
      count_q    <= CNT_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      wr_ptr_q   <= PTR_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_ip_q <= fetch_ip_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      buf_q      <= buf_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign fetch_ip = fetch_ip_q;
  assign q_count  = count_q;
  assign q_valid  = (count_q != CNT_ZERO);
  assign q_byte   = buf_q[rd_ptr_q];

`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_fetches_q, stat_fetches_d;
  logic [15:0] stat_flushes_q, stat_flushes_d;

  // Saturating statistics counters. A flush does not clear them.
  always_comb begin
    stat_fetches_d = stat_fetches_q;
    stat_flushes_d = stat_flushes_q;
    if (push_s && (stat_fetches_q != 16'hFFFF)) begin
      stat_fetches_d = stat_fetches_q + 16'd1;
    end else begin
      stat_fetches_d = stat_fetches_q;
    end
    if (flush && (stat_flushes_q != 16'hFFFF)) begin
      stat_flushes_d = stat_flushes_q + 16'd1;
    end else begin
      stat_flushes_d = stat_flushes_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetches_q <= 16'h0000;
      stat_flushes_q <= 16'h0000;
    end else begin
      stat_fetches_q <= stat_fetches_d;
      stat_flushes_q <= stat_flushes_d;
    end
  end

  assign stat_fetches = stat_fetches_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_prefetch_queue
//
// Directed testbench for prefetch_queue (DEPTH=6). A single initial block
// drives the stimulus. At every comparison point an immediate assertion checks
// the DUT against a hand-computed expected value.
// -----------------------------------------------------------------------------
module tb_prefetch_queue;

  logic        clk;
  logic        rst;
  logic [15:0] cs_in;
  logic        flush;
  logic [15:0] flush_ip;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        q_valid;
  logic [7:0]  q_byte;
  logic        q_pop;
  logic [3:0]  q_count;
  logic [15:0] fetch_ip;
`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_fetches;
  logic [15:0] stat_flushes;
`endif

  int checks = 0;
  int errors = 0;
  logic ack_mode;

  prefetch_queue #(.DEPTH(6), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs_in     (cs_in),
    .flush     (flush),
    .flush_ip  (flush_ip),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .q_valid   (q_valid),
    .q_byte    (q_byte),
    .q_pop     (q_pop),
    .q_count   (q_count),
    .fetch_ip  (fetch_ip)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_fetches (stat_fetches),
    .stat_flushes (stat_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // The memory model acks only while ack_mode is set and a request is
  // pending. It returns the low address byte as data. Inputs change 1 time
  // unit after the rising edge.
  task automatic tick();
    mem_ack   = ack_mode & mem_req;
    mem_rdata = mem_addr[7:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cs_in = 16'h1000; flush = 1'b0; flush_ip = 16'h0000;
    mem_ack = 1'b0; mem_rdata = 8'h00; q_pop = 1'b0; ack_mode = 1'b0;
    tick();
    tick();
    chk("rst_req",   32'(mem_req),  32'h0);
    chk("rst_addr",  32'(mem_addr), 32'h0);
    chk("rst_valid", 32'(q_valid),  32'h0);
    chk("rst_byte",  32'(q_byte),   32'h0);
    chk("rst_count", 32'(q_count),  32'h0);
    chk("rst_ip",    32'(fetch_ip), 32'h0);

    // Fill from start.
    rst = 1'b0; flush = 1'b1; flush_ip = 16'h0000;
    tick();
    flush = 1'b0;
    chk("flush0_req", 32'(mem_req), 32'h0);
    ack_mode = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("fill_req",  32'(mem_req),  32'h1);
      chk("fill_addr", 32'(mem_addr), 32'h10000 + 32'(i));
      tick();
    end
    chk("full_count", 32'(q_count),  32'h6);
    chk("full_ip",    32'(fetch_ip), 32'h0006);
    chk("full_req",   32'(mem_req),  32'h0);
    chk("full_valid", 32'(q_valid),  32'h1);
    chk("full_head",  32'(q_byte),   32'h00);
`ifdef PREFETCH_STATS_EN
    chk("stat_fetch_fill", 32'(stat_fetches), 32'd6);
    chk("stat_flush_fill", 32'(stat_flushes), 32'd1);
`endif
    tick();
    chk("full_stays_idle", 32'(mem_req), 32'h0);

    // Pop resumes fetching.
    q_pop = 1'b1;
    tick();
    q_pop = 1'b0;
    chk("pop_count", 32'(q_count), 32'h5);
    chk("pop_head",  32'(q_byte),  32'h01);
    tick();
    chk("resume_req",  32'(mem_req),  32'h1);
    chk("resume_addr", 32'(mem_addr), 32'h10006);
    tick();
    chk("refill_count", 32'(q_count),  32'h6);
    chk("refill_ip",    32'(fetch_ip), 32'h0007);
    chk("refill_req",   32'(mem_req),  32'h0);

    // Wait states, then a flush in the same cycle as the ack.
    ack_mode = 1'b0;
    q_pop = 1'b1;
    tick();
    q_pop = 1'b0;
    tick();
    chk("wait_req0",  32'(mem_req),  32'h1);
    chk("wait_addr0", 32'(mem_addr), 32'h10007);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req",  32'(mem_req),  32'h1);
      chk("wait_addr", 32'(mem_addr), 32'h10007);
    end
    ack_mode = 1'b1; flush = 1'b1; flush_ip = 16'h0100;
    tick();
    ack_mode = 1'b0; flush = 1'b0;
    chk("fl_count", 32'(q_count),  32'h0);
    chk("fl_valid", 32'(q_valid),  32'h0);
    chk("fl_req",   32'(mem_req),  32'h0);
    chk("fl_ip",    32'(fetch_ip), 32'h0100);
`ifdef PREFETCH_STATS_EN
    chk("stat_fetch_fl", 32'(stat_fetches), 32'd7);
    chk("stat_flush_fl", 32'(stat_flushes), 32'd2);
`endif
    tick();
    chk("fl_new_req",  32'(mem_req),  32'h1);
    chk("fl_new_addr", 32'(mem_addr), 32'h10100);
    chk("fl_no_byte",  32'(q_count),  32'h0);

    // Fill to 3 bytes (00, 01, 02); the request for 0x10103 stays pending.
    ack_mode = 1'b1;
    tick();
    tick();
    tick();
    chk("c3_count", 32'(q_count),  32'h3);
    chk("c3_addr",  32'(mem_addr), 32'h10103);
    // Push and pop in the same cycle.
    q_pop = 1'b1;
    tick();
    ack_mode = 1'b0; q_pop = 1'b0;
    chk("pp_count", 32'(q_count), 32'h3);
    chk("pp_head",  32'(q_byte),  32'h01);
    q_pop = 1'b1;
    tick();
    chk("pp_ord1", 32'(q_byte), 32'h02);
    tick();
    chk("pp_ord2", 32'(q_byte), 32'h03);
    tick();
    chk("pp_empty_valid", 32'(q_valid), 32'h0);
    // Pop while empty has no effect.
    tick();
    q_pop = 1'b0;
    chk("pe_count", 32'(q_count),  32'h0);
    chk("pe_valid", 32'(q_valid),  32'h0);
    chk("pe_req",   32'(mem_req),  32'h1);
    chk("pe_addr",  32'(mem_addr), 32'h10104);
    chk("pe_ip",    32'(fetch_ip), 32'h0104);

    // Physical address wrap: 0xFFFF0 + 0x0010 gives 0x00000.
    cs_in = 16'hFFFF; flush = 1'b1; flush_ip = 16'h0010;
    tick();
    flush = 1'b0;
    tick();
    chk("aw_req",  32'(mem_req),  32'h1);
    chk("aw_addr", 32'(mem_addr), 32'h00000);

    // IP wrap.
    cs_in = 16'h0000; flush = 1'b1; flush_ip = 16'hFFFF;
    tick();
    flush = 1'b0;
    tick();
    chk("iw_addr0", 32'(mem_addr), 32'h0FFFF);
    ack_mode = 1'b1;
    tick();
    ack_mode = 1'b0;
    chk("iw_ip",   32'(fetch_ip), 32'h0000);
    chk("iw_addr", 32'(mem_addr), 32'h00000);
    chk("iw_req",  32'(mem_req),  32'h1);
    chk("iw_byte", 32'(q_byte),   32'hFF);

    // Reset during a request with an ack in the same cycle.
    rst = 1'b1; ack_mode = 1'b1;
    tick();
    rst = 1'b0; ack_mode = 1'b0;
    chk("rr_req",   32'(mem_req),  32'h0);
    chk("rr_count", 32'(q_count),  32'h0);
    chk("rr_ip",    32'(fetch_ip), 32'h0);
`ifdef PREFETCH_STATS_EN
    chk("rr_stat_f", 32'(stat_fetches), 32'd0);
    chk("rr_stat_l", 32'(stat_flushes), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Instruction prefetch stage, directly downstream of the segment register file.
- Consumes the code segment value (cs_out), keeps a 16-bit fetch IP, and forms 20-bit physical addresses as (CS << 4) + IP.
- Issues byte reads on a req/ack memory port and buffers the fetched bytes in a small FIFO for the decoder.
- On a flush, the queue is discarded and prefetch restarts at a new IP (jumps, CS writes).

Parameters:
- DEPTH, 6, queue capacity in bytes; legal range 2..15.
- CNT_W, 4, width of q_count; must hold the value DEPTH.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cs_in  input  16  code segment, from segment register file cs_out
- flush  input  1  discard queue and restart fetch at flush_ip
- flush_ip  input  16  new fetch IP, sampled when flush=1
- mem_req  output  1  read request, held until acknowledged
- mem_addr  output  20  physical byte address, stable while mem_req=1
- mem_ack  input  1  memory accepts request; mem_rdata valid this cycle
- mem_rdata  input  8  read byte
- q_valid  output  1  queue non-empty
- q_byte  output  8  byte at queue head, valid when q_valid=1
- q_pop  input  1  decoder consumes head byte
- q_count  output  CNT_W  bytes currently held
- fetch_ip  output  16  IP of the next byte to be requested

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high and has top priority.
- Reset values:
  - mem_req=0, mem_addr=0, q_valid=0, q_byte=0, q_count=0, fetch_ip=0.
  - FSM in IDLE; internal read/write pointers at 0.
- FSM states: IDLE, REQ.
- IDLE -> REQ:
  - Condition: q_count < DEPTH and flush=0.
  - Next cycle: mem_req=1 and mem_addr = ({cs_in,4'h0} + {4'h0,fetch_ip}) mod 2^20, with the carry out of bit 19 discarded.
  - cs_in is sampled at issue. mem_addr then holds constant for the whole request.
- REQ, mem_ack=1, flush=0:
  - mem_rdata is written at the tail; q_count increments; fetch_ip <= fetch_ip+1 (16-bit wrap, 0xFFFF -> 0x0000).
  - If space still remains after this push (count after push < DEPTH), the next request issues back-to-back: mem_req stays 1 and mem_addr takes the new address the next cycle. Otherwise the FSM returns to IDLE with mem_req=0.
- REQ, mem_ack=0: hold mem_req and mem_addr unchanged.
- mem_ack while mem_req=0: ignored.
- At most one request is outstanding, so the queue never overflows.
- Pop:
  - q_pop with q_valid=1 advances the head and decrements q_count.
  - q_pop while empty: ignored; no state change.
- Push and pop in the same cycle: q_count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- q_byte always shows the head entry. The first byte is visible (q_valid=1) the cycle after its mem_ack.
- flush (priority below rst, above ack and pop):
  - Next cycle: q_count=0, q_valid=0, pointers=0, fetch_ip=flush_ip, FSM=IDLE, mem_req=0.
  - An ack in the flush cycle is discarded; an ack arriving later is already ignored because mem_req=0.
  - The first new request issues no earlier than 2 cycles after flush.
- Latency:
  - Empty queue to first request: 1 cycle.
  - mem_ack to q_valid: 1 cycle.
- rst mid-request: mem_req drops the next cycle; an ack in the reset cycle is discarded.
- cs_in changing mid-request does not affect the pending mem_addr. Software issues a flush after any CS write.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- When defined, two extra outputs exist:
  - stat_fetches [15:0]: counts accepted mem_ack pushes.
  - stat_flushes [15:0]: counts flush cycles.
- Both counters saturate at 0xFFFF, reset to 0 on rst, and are not cleared by flush.
- When not defined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Fill from start:
  - Stimulus: rst for 2 cycles, then flush with flush_ip=0x0000, cs_in=0x1000, mem_ack=1 every cycle in which mem_req=1, mem_rdata=low byte of address.
  - Response: mem_addr sequence 0x10000..0x10005; requests stop with q_count=6 and fetch_ip=0x0006.
- Pop resumes fetch:
  - Stimulus: from the full state, pop once.
  - Response: q_byte=0x00 popped; next request at 0x10006; q_count returns to 6.
- Wait states and flush:
  - Stimulus: hold mem_ack=0 for 3 cycles, then assert flush with flush_ip=0x0100 in the same cycle as mem_ack=1.
  - Response: mem_addr stays stable during the wait; the acked byte is not queued; q_count=0; next request at (CS<<4)+0x0100.
- Address wrap:
  - Stimulus: cs_in=0xFFFF, fetch from IP=0x0010.
  - Response: mem_addr=0x00000.
- IP wrap:
  - Stimulus: cs_in=0x0000, fetch from IP=0xFFFF.
  - Response: fetch_ip wraps to 0x0000 and the next address is 0x00000.
- Concurrent push and pop:
  - Stimulus: q_count=3, mem_ack and q_pop in the same cycle.
  - Response: q_count stays 3 and byte order is preserved.
- Pop while empty:
  - Stimulus: q_pop with q_valid=0.
  - Response: no change.
- Stats build (PREFETCH_STATS_EN defined):
  - Stimulus: the fill scenario plus 1 flush.
  - Response: stat_fetches=6, stat_flushes=2 (counting the startup flush).
